// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle add/sub/logic/compare/shift ops plus iterative
// shift-add multiply and restoring divide/remainder, with a registered result.
module alu_seq #(
    parameter  int WIDTH   = 32,
    parameter  int ALUOP_W = 4,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [ALUOP_W-1:0] m,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   y,
    output logic               zf,
    output logic               cf,
    output logic               of,
    output logic               dz
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [ALUOP_W-1:0] OP_ADD  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] OP_SUB  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] OP_AND  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] OP_OR   = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] OP_XOR  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] OP_SLT  = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] OP_SLTU = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] OP_SLL  = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] OP_SRL  = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] OP_SRA  = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] OP_MUL  = ALUOP_W'(10);
    localparam logic [ALUOP_W-1:0] OP_DIVU = ALUOP_W'(11);
    localparam logic [ALUOP_W-1:0] OP_REMU = ALUOP_W'(12);

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             zf;
        logic             cf;
        logic             of;
        logic             dz;
    } res_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    res_t               res, sc_res, it_res;
    logic [WIDTH-1:0]   ra, rb, acc;
    logic [ALUOP_W-1:0] mq;
    logic [CNT_W-1:0]   cnt;
    logic               accept, is_multi, it_last;
    logic [WIDTH:0]     sum, dif, div_sh, div_df;
    logic [SHAMT_W-1:0] shamt;

    assign accept   = in_valid & in_ready;
    assign is_multi = (m == OP_MUL) || (m == OP_DIVU) || (m == OP_REMU);
    assign it_last  = (cnt == CNT_W'(WIDTH));
    assign shamt    = b[SHAMT_W-1:0];

    assign out_valid = (state == DONE);
    assign y  = res.y;
    assign zf = res.zf;
    assign cf = res.cf;
    assign of = res.of;
    assign dz = res.dz;

    // Single-cycle result, computed straight from the input operands.
    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        dif    = {1'b0, a} - {1'b0, b};
        sc_res = '0;
        case (m)
            OP_ADD: begin
                sc_res.y  = sum[WIDTH-1:0];
                sc_res.cf = sum[WIDTH];
                sc_res.of = (~a[WIDTH-1] & ~b[WIDTH-1] & sum[WIDTH-1]) |
                            ( a[WIDTH-1] &  b[WIDTH-1] & ~sum[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res.y  = dif[WIDTH-1:0];
                sc_res.cf = dif[WIDTH];
                sc_res.of = (~a[WIDTH-1] &  b[WIDTH-1] & dif[WIDTH-1]) |
                            ( a[WIDTH-1] & ~b[WIDTH-1] & ~dif[WIDTH-1]);
            end
            OP_AND:  sc_res.y = a & b;
            OP_OR:   sc_res.y = a | b;
            OP_XOR:  sc_res.y = a ^ b;
            OP_SLT:  sc_res.y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: sc_res.y = {{(WIDTH-1){1'b0}}, a < b};
            OP_SLL:  sc_res.y = a << shamt;
            OP_SRL:  sc_res.y = a >> shamt;
            OP_SRA:  sc_res.y = WIDTH'($signed(a) >>> shamt);
            default: sc_res.y = '0;
        endcase
        sc_res.zf = (sc_res.y == '0);
    end

    // Restoring-division step: ra shifts the dividend out MSB first and the
    // quotient in LSB first; acc holds the partial remainder.
    assign div_sh = {acc, ra[WIDTH-1]};
    assign div_df = div_sh - {1'b0, rb};

    always_comb begin
        it_res = '0;
        case (mq)
            OP_MUL:  it_res.y = acc;
            OP_DIVU: it_res.y = ra;
            default: it_res.y = acc;
        endcase
        it_res.dz = (mq != OP_MUL) && (rb == '0);
        it_res.zf = (it_res.y == '0);
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            BUSY: if (it_last) state_nxt = DONE;
            DONE: begin
                in_ready = out_ready;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (accept) state_nxt = is_multi ? BUSY : DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res <= '0;
            ra  <= '0;
            rb  <= '0;
            acc <= '0;
            mq  <= '0;
            cnt <= '0;
        end else if (accept) begin
            if (is_multi) begin
                ra  <= a;
                rb  <= b;
                acc <= '0;
                mq  <= m;
                cnt <= '0;
            end else begin
                res <= sc_res;
            end
        end else if (state == BUSY) begin
            if (it_last) begin
                res <= it_res;
            end else begin
                cnt <= cnt + CNT_W'(1);
                if (mq == OP_MUL) begin
                    acc <= acc + (rb[0] ? ra : '0);
                    ra  <= ra << 1;
                    rb  <= rb >> 1;
                end else begin
                    acc <= div_df[WIDTH] ? div_sh[WIDTH-1:0] : div_df[WIDTH-1:0];
                    ra  <= {ra[WIDTH-2:0], ~div_df[WIDTH]};
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq, checked every cycle against a
// transaction-level model of results, latency and handshake.
module tb_alu_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0, in_ready;
    logic [W-1:0] a = '0, b = '0, y;
    logic [3:0]   m = '0;
    logic         out_valid, out_ready = 1'b0;
    logic         zf, cf, of, dz;

    int ncmp = 0, nerr = 0, cyc = 0;

    typedef struct {
        logic [W+3:0] r;
        int           due;
    } exp_t;
    exp_t q[$];

    alu_seq #(.WIDTH(W), .ALUOP_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .m(m), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .zf(zf), .cf(cf), .of(of), .dz(dz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected {y,zf,cf,of,dz} from the opcode definitions.
    function automatic logic [W+3:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                           input logic [3:0] tm);
        logic [W-1:0] ry;
        logic rc, ro, rd;
        int sh;
        ry = '0; rc = 0; ro = 0; rd = 0;
        sh = int'(tb % W);
        case (tm)
            0: begin
                ry = ta + tb;
                rc = (longint'(ta) + longint'(tb)) >= 64'h1_0000_0000;
                ro = (ta[W-1] == tb[W-1]) && (ry[W-1] != ta[W-1]);
            end
            1: begin
                ry = ta - tb;
                rc = ta < tb;
                ro = (ta[W-1] != tb[W-1]) && (ry[W-1] != ta[W-1]);
            end
            2: ry = ta & tb;
            3: ry = ta | tb;
            4: ry = ta ^ tb;
            5: ry = W'($signed(ta) < $signed(tb));
            6: ry = W'(ta < tb);
            7: ry = ta << sh;
            8: ry = ta >> sh;
            9: ry = W'($signed(ta) >>> sh);
            10: ry = W'(longint'(ta) * longint'(tb));
            11: begin ry = (tb == 0) ? '1 : ta / tb; rd = (tb == 0); end
            12: begin ry = (tb == 0) ? ta : ta % tb; rd = (tb == 0); end
            default: ry = '0;
        endcase
        return {ry, ry == 0, rc, ro, rd};
    endfunction

    // Per-cycle compare: handshake timing and held results against the model.
    always @(negedge clk) begin
        logic exp_ov, exp_ir;
        if (!rst_n) begin
            q.delete();
        end else begin
            exp_ov = (q.size() > 0) && (cyc >= q[0].due);
            exp_ir = (q.size() == 0) ? 1'b1 : (exp_ov ? out_ready : 1'b0);
            chk("out_valid", 64'(out_valid), 64'(exp_ov));
            chk("in_ready", 64'(in_ready), 64'(exp_ir));
            if (exp_ov && out_valid)
                chk("result", 64'({y, zf, cf, of, dz}), 64'(q[0].r));
            if (exp_ov && out_ready) void'(q.pop_front());
            if (in_valid && exp_ir)
                q.push_back('{model(a, b, m),
                              cyc + ((m >= 10 && m <= 12) ? W + 2 : 1)});
        end
    end

    task automatic wait_accept();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (!in_ready) chk("accept timeout", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        if (!out_valid) chk("valid timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic run(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic [3:0] tm, input logic [W+3:0] ev, input string nm);
        in_valid = 1'b1; a = ta; b = tb; m = tm; out_ready = 1'b1;
        wait_accept();
        wait_valid();
        chk(nm, 64'({y, zf, cf, of, dz}), 64'(ev));
        @(posedge clk); #1;
    endtask

    initial begin
        // Model pins from hand arithmetic.
        chk("model add", 64'(model(32'h7FFFFFFF, 32'h1, 4'd0)), 64'({32'h80000000, 4'b0010}));
        chk("model sub", 64'(model(32'h0, 32'h1, 4'd1)), 64'({32'hFFFFFFFF, 4'b0100}));
        chk("model mul", 64'(model(32'h00010003, 32'h5, 4'd10)), 64'({32'h0005000F, 4'b0000}));
        chk("model rem", 64'(model(32'd100, 32'd7, 4'd12)), 64'({32'd2, 4'b0000}));
        chk("model sra", 64'(model(32'h80000000, 32'h24, 4'd9)), 64'({32'hF8000000, 4'b0000}));

        repeat (3) @(posedge clk);
        #1;
        chk("reset out", 64'({out_valid, in_ready, y, zf, cf, of, dz}), 64'({2'b01, 36'h0}));
        rst_n = 1'b1;

        run(32'h7FFFFFFF, 32'h00000001, 4'd0,  {32'h80000000, 4'b0010}, "add ovf");
        run(32'h5,        32'h5,        4'd1,  {32'h0,        4'b1000}, "sub zero");
        run(32'h0,        32'h1,        4'd1,  {32'hFFFFFFFF, 4'b0100}, "sub borrow");
        run(32'hFFFFFFFF, 32'h1,        4'd5,  {32'h1,        4'b0000}, "slt");
        run(32'hFFFFFFFF, 32'h1,        4'd6,  {32'h0,        4'b1000}, "sltu");
        run(32'h80000000, 32'h24,       4'd9,  {32'hF8000000, 4'b0000}, "sra");
        run(32'h00010003, 32'h5,        4'd10, {32'h0005000F, 4'b0000}, "mul");
        run(32'd100,      32'd7,        4'd11, {32'd14,       4'b0000}, "divu");
        run(32'd100,      32'd7,        4'd12, {32'd2,        4'b0000}, "remu");
        run(32'd9,        32'd0,        4'd11, {32'hFFFFFFFF, 4'b0001}, "divu by 0");
        run(32'd9,        32'd0,        4'd12, {32'd9,        4'b0001}, "remu by 0");
        run(32'h1234,     32'h5678,     4'd14, {32'h0,        4'b1000}, "undef op");

        // Back-pressure, then same-cycle consume and accept.
        out_ready = 1'b0; in_valid = 1'b1; a = 32'd10; b = 32'd20; m = 4'd0;
        wait_accept();
        wait_valid();
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b1; a = 32'd2; b = 32'd3; m = 4'd0; out_ready = 1'b1;
        @(negedge clk);
        chk("same-cycle accept", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b add", 64'({out_valid, y}), 64'({1'b1, 32'd5}));
        @(posedge clk); #1;

        // Reset in the middle of a divide.
        in_valid = 1'b1; a = 32'hDEADBEEF; b = 32'd7; m = 4'd11;
        wait_accept();
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid-busy reset", 64'({out_valid, in_ready, y, zf, cf, of, dz}), 64'({2'b01, 36'h0}));
        @(posedge clk); #1;
        rst_n = 1'b1;
        run(32'd40, 32'd2, 4'd0, {32'd42, 4'b0000}, "after reset");

        // Random traffic with random back-pressure.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 3) != 0);
            m = 4'($urandom_range(0, 15));
            a = $urandom();
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = W'($urandom_range(0, 40));
                default: b = $urandom();
            endcase
            if ($urandom_range(0, 7) == 0) a = W'($urandom_range(0, 3));
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (W + 5) @(posedge clk);
        #1;
        chk("drained", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
